instr_fetch_unit: RTL

Instruction-supply end of the core's `instruction` input. It replaces hand-driven instruction words with real fetches from an instruction memory. The core presents `pc` and `fetch_en`. The block returns the 32-bit word from a one-entry tagged buffer, or runs a req/ack memory transaction on a miss and stalls the core until the word is ready. Misaligned PCs, memory errors and timeouts yield a NOP (addi x0,x0,0) flagged as a fault.

---
 rtl/instr_fetch_unit.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: one-entry tagged instruction buffer in front of a req/ack
// instruction memory. Misses stall the core while a single memory read is in
// flight. Misaligned PCs, memory errors and timeouts return a NOP flagged as a
// fault, so the core always has a well-defined word to execute.
module instr_fetch_unit #(
    parameter int          TIMEOUT_CYCLES = 16,
    parameter logic [31:0] NOP_INSTR      = 32'h00000013
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [31:0] pc,
    input  logic        fetch_en,
    input  logic        flush,
    output logic [31:0] instruction,
    output logic        instr_valid,
    output logic        instr_fault,
    output logic        stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        mem_err
);

    // Timer must be at least one bit wide even for the smallest legal timeout.
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t        state, state_d;
    logic [31:0]   tag_q, tag_d;
    logic [31:0]   data_q, data_d;
    logic          cvalid_q, cvalid_d;
    logic          fault_q, fault_d;
    logic [31:0]   addr_q, addr_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          discard_q, discard_d;

    logic          hit;
    logic          fill_en;
    logic [31:0]   fill_data;
    logic          fill_fault;

    assign hit = cvalid_q && (tag_q == pc);

    // Core-facing outputs: the buffer is only trusted while idle and unflushed.
    assign instruction = data_q;
    assign instr_valid = fetch_en && hit && (state == IDLE) && !flush;
    assign instr_fault = instr_valid && fault_q;
    assign stall       = fetch_en && !instr_valid;
    assign mem_req     = (state == REQ);
    assign mem_addr    = addr_q;

    // Next-state and buffer-update logic; flush has the final word on cvalid.
    always_comb begin
        state_d    = state;
        tag_d      = tag_q;
        data_d     = data_q;
        cvalid_d   = cvalid_q;
        fault_d    = fault_q;
        addr_d     = addr_q;
        timer_d    = timer_q;
        discard_d  = discard_q;
        fill_en    = 1'b0;
        fill_data  = NOP_INSTR;
        fill_fault = 1'b1;

        case (state)
            IDLE: begin
                if (fetch_en && !hit) begin
                    if (pc[1:0] != 2'b00) begin
                        // Misaligned: synthesize a faulting NOP without touching memory.
                        tag_d    = pc;
                        data_d   = NOP_INSTR;
                        fault_d  = 1'b1;
                        cvalid_d = 1'b1;
                    end else begin
                        addr_d    = pc;
                        timer_d   = '0;
                        discard_d = 1'b0;
                        state_d   = REQ;
                    end
                end
            end
            REQ: begin
                if (mem_ack) begin
                    // Ack wins over a same-cycle timeout.
                    fill_en    = 1'b1;
                    fill_data  = mem_err ? NOP_INSTR : mem_rdata;
                    fill_fault = mem_err;
                    state_d    = IDLE;
                end else if (timer_q == TIMER_LAST) begin
                    fill_en    = 1'b1;
                    fill_data  = NOP_INSTR;
                    fill_fault = 1'b1;
                    state_d    = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
                // A flush anywhere in the transaction poisons its result.
                if (flush) begin
                    discard_d = 1'b1;
                end
                if (fill_en && !discard_q && !flush) begin
                    tag_d    = addr_q;
                    data_d   = fill_data;
                    fault_d  = fill_fault;
                    cvalid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            cvalid_d = 1'b0;
        end
    end

    // State and buffer registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state     <= IDLE;
            tag_q     <= '0;
            data_q    <= NOP_INSTR;
            cvalid_q  <= 1'b0;
            fault_q   <= 1'b0;
            addr_q    <= '0;
            timer_q   <= '0;
            discard_q <= 1'b0;
        end else begin
            state     <= state_d;
            tag_q     <= tag_d;
            data_q    <= data_d;
            cvalid_q  <= cvalid_d;
            fault_q   <= fault_d;
            addr_q    <= addr_d;
            timer_q   <= timer_d;
            discard_q <= discard_d;
        end
    end

endmodule
